// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
//   Shared constants for the countdown timer.
//   - ST_IDLE / ST_RUN / ST_PAUSE / ST_DONE : 3-bit state codes. These are the
//     values that appear on actual_state, so the VGA painter relies on them.
//   - BCD_MAX / SEC_TENS_MAX : largest legal value of a BCD digit and of the
//     seconds-tens digit.
//   - clamp_digit() : limits a preset digit to a given maximum.
// -----------------------------------------------------------------------------
package timer_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_RUN   = 3'd1;
   localparam logic [2:0] ST_PAUSE = 3'd2;
   localparam logic [2:0] ST_DONE  = 3'd3;

   localparam logic [3:0] BCD_MAX      = 4'd9;
   localparam logic [3:0] SEC_TENS_MAX = 4'd5;

   function automatic logic [3:0] clamp_digit(input logic [3:0] i_digit,
                                              input logic [3:0] i_max);
      return (i_digit > i_max) ? i_max : i_digit;
   endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// -----------------------------------------------------------------------------
// bcd_down_digit
//   One stage of a BCD down-counting borrow chain. This stage is purely
//   combinational; the digit register lives in the top level.
//   Parameter:
//     MAX_VAL  - value the digit wraps to when it borrows from 0.
//   Ports:
//     i_digit  in  4  current digit value
//     i_borrow in  1  decrement request from the less significant stage
//     o_digit  out 4  digit value after the (optional) decrement
//     o_borrow out 1  decrement request for the more significant stage
// -----------------------------------------------------------------------------
module bcd_down_digit
   import timer_pkg::*;
#(
   parameter logic [3:0] MAX_VAL = BCD_MAX
)(
   input  logic [3:0] i_digit,
   input  logic       i_borrow,
   output logic [3:0] o_digit,
   output logic       o_borrow
);

   always_comb begin
      o_digit  = i_digit;
      o_borrow = 1'b0;
      if (i_borrow) begin
         if (i_digit == 4'd0) begin
            o_digit  = MAX_VAL;
            o_borrow = 1'b1;
         end else begin
            o_digit  = i_digit - 4'd1;
         end
      end
   end

endmodule

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//   BCD MM:SS countdown timer. It loads preset digits and is started or paused
//   by a single-cycle pulse. While running it decrements once per second, using
//   a prescaler that counts clk_100MHz cycles. It is the time source for the VGA
//   painter.
//
//   Build option:
//     TIMER_AUTORELOAD_EN - when defined, DONE lasts DONE_HOLD_S seconds. After
//                           that the last loaded preset is restored from a
//                           shadow register and the timer returns to IDLE.
//                           When not defined, DONE holds until a load or a
//                           reset.
//
//   Parameters:
//     CLK_HZ       clock frequency; the prescaler period in cycles (>= 2)
//     DONE_HOLD_S  seconds spent in DONE before auto-reload (>= 1)
//
//   Ports:
//     clk_100MHz     in   1  system clock
//     reset          in   1  asynchronous, active-high reset
//     load           in   1  level; copy clamped preset digits into the counter
//     start_pause    in   1  pulse; toggles run/pause
//     set_m_decimal  in   4  preset minutes tens  (BCD)
//     set_m_unit     in   4  preset minutes units (BCD)
//     set_s_decimal  in   4  preset seconds tens  (BCD)
//     set_s_unit     in   4  preset seconds units (BCD)
//     m_decimal      out  4  minutes tens
//     m_unit         out  4  minutes units
//     s_decimal      out  4  seconds tens
//     s_unit         out  4  seconds units
//     actual_state   out  3  IDLE=0, RUN=1, PAUSE=2, DONE=3
//     finish         out  1  high while in DONE
//     tick_1hz       out  1  one-cycle pulse on each decrement in RUN
// -----------------------------------------------------------------------------
module countdown_timer
   import timer_pkg::*;
#(
   parameter int CLK_HZ      = 100000000,
   parameter int DONE_HOLD_S = 5
)(
   input  logic       clk_100MHz,
   input  logic       reset,
   input  logic       load,
   input  logic       start_pause,
   input  logic [3:0] set_m_decimal,
   input  logic [3:0] set_m_unit,
   input  logic [3:0] set_s_decimal,
   input  logic [3:0] set_s_unit,
   output logic [3:0] m_decimal,
   output logic [3:0] m_unit,
   output logic [3:0] s_decimal,
   output logic [3:0] s_unit,
   output logic [2:0] actual_state,
   output logic       finish,
   output logic       tick_1hz
);

   // Reject parameter values that would give a zero-width prescaler or an
   // empty hold period.
   if (CLK_HZ < 2 || DONE_HOLD_S < 1) begin : g_bad_params
      $error("countdown_timer: CLK_HZ must be >= 2 and DONE_HOLD_S >= 1");
   end

   localparam int            PW             = $clog2(CLK_HZ);
   localparam logic [PW-1:0] PRESCALE_LAST  = PW'(CLK_HZ - 1);

   // Digit arrays are indexed from least significant: 0 = s_unit,
   // 1 = s_decimal, 2 = m_unit, 3 = m_decimal.
   logic [3:0][3:0] r_digits;
   logic [3:0][3:0] w_digits_next;
   logic [3:0][3:0] w_set_raw;
   logic [3:0][3:0] w_preset;
   logic [3:0][3:0] w_dec;
   logic [4:0]      w_borrow;

   logic [2:0]      r_state;
   logic [2:0]      w_state_next;
   logic [PW-1:0]   r_prescale;
   logic [PW-1:0]   w_prescale_next;
   logic            r_tick;
   logic            w_tick_next;
   logic            r_finish;
   logic            w_finish_next;

   logic            w_terminal;
   logic            w_is_zero;
   logic            w_dec_is_zero;

`ifdef TIMER_AUTORELOAD_EN
   localparam int            HW        = $clog2(DONE_HOLD_S + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(DONE_HOLD_S - 1);

   logic [3:0][3:0] r_shadow;
   logic [3:0][3:0] w_shadow_next;
   logic [HW-1:0]   r_hold;
   logic [HW-1:0]   w_hold_next;
`endif

   assign w_set_raw = {set_m_decimal, set_m_unit, set_s_decimal, set_s_unit};

   // ------------------------------------------------------------------------
   // Per-digit preset clamp and decrement borrow chain. The chain always
   // computes "value - 1"; the FSM decides whether to take the result.
   // ------------------------------------------------------------------------
   assign w_borrow[0] = 1'b1;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_digit
         localparam logic [3:0] MAXV = (gi == 1) ? SEC_TENS_MAX : BCD_MAX;

         assign w_preset[gi] = clamp_digit(w_set_raw[gi], MAXV);

         bcd_down_digit #(
            .MAX_VAL (MAXV)
         ) u_digit (
            .i_digit  (r_digits[gi]),
            .i_borrow (w_borrow[gi]),
            .o_digit  (w_dec[gi]),
            .o_borrow (w_borrow[gi+1])
         );
      end
   endgenerate

   // A borrow out of the most significant digit happens only when every digit
   // is 0, so it doubles as the 00:00 detector.
   assign w_is_zero     = w_borrow[4];
   // Only 00:01 decrements to 00:00.
   assign w_dec_is_zero = (w_dec == '0);
   assign w_terminal    = (r_prescale == PRESCALE_LAST);

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_digits   <= '0;
         r_prescale <= '0;
         r_tick     <= 1'b0;
         r_finish   <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_digits   <= w_digits_next;
         r_prescale <= w_prescale_next;
         r_tick     <= w_tick_next;
         r_finish   <= w_finish_next;
      end
   end

`ifdef TIMER_AUTORELOAD_EN
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         r_shadow <= '0;
         r_hold   <= '0;
      end else begin
         r_shadow <= w_shadow_next;
         r_hold   <= w_hold_next;
      end
   end
`endif

   // ------------------------------------------------------------------------
   // Next-state and datapath logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next    = r_state;
      w_digits_next   = r_digits;
      w_prescale_next = r_prescale;
`ifdef TIMER_AUTORELOAD_EN
      w_shadow_next   = r_shadow;
      w_hold_next     = r_hold;
`endif

      case (r_state)
         ST_IDLE: begin
            // load wins over a simultaneous start_pause.
            if (load) begin
               w_digits_next = w_preset;
            end else if (start_pause) begin
               w_prescale_next = '0;
               w_state_next    = w_is_zero ? ST_DONE : ST_RUN;
            end
         end

         ST_RUN: begin
            // load is ignored while running.
            if (w_terminal) begin
               w_prescale_next = '0;
               w_digits_next   = w_dec;
               // Reaching 00:00 takes priority over a coincident pause.
               if (w_dec_is_zero) begin
                  w_state_next = ST_DONE;
               end else if (start_pause) begin
                  w_state_next = ST_PAUSE;
               end
            end else begin
               w_prescale_next = r_prescale + 1'b1;
               if (start_pause) begin
                  w_state_next = ST_PAUSE;
               end
            end
         end

         ST_PAUSE: begin
            // The prescaler keeps its value here, so a resume continues the
            // partially elapsed second.
            if (load) begin
               w_digits_next = w_preset;
               w_state_next  = ST_IDLE;
            end else if (start_pause) begin
               w_state_next  = ST_RUN;
            end
         end

         ST_DONE: begin
            if (load) begin
               w_digits_next = w_preset;
               w_state_next  = ST_IDLE;
            end
`ifdef TIMER_AUTORELOAD_EN
            else if (w_terminal) begin
               w_prescale_next = '0;
               if (r_hold == HOLD_LAST) begin
                  w_digits_next = r_shadow;
                  w_state_next  = ST_IDLE;
               end else begin
                  w_hold_next = r_hold + 1'b1;
               end
            end else begin
               w_prescale_next = r_prescale + 1'b1;
            end
`endif
         end

         default: begin
            w_state_next = ST_IDLE;
         end
      endcase

`ifdef TIMER_AUTORELOAD_EN
      // The shadow follows every load that is accepted, which is every state
      // except RUN.
      if (load && (r_state != ST_RUN)) begin
         w_shadow_next = w_preset;
      end
      // Each visit to DONE starts a fresh hold period.
      if (w_state_next != ST_DONE) begin
         w_hold_next = '0;
      end
`endif
   end

   // ------------------------------------------------------------------------
   // Output decode, registered on the same edge as the state
   // ------------------------------------------------------------------------
   always_comb begin
      w_tick_next   = (r_state == ST_RUN) && w_terminal;
      w_finish_next = (w_state_next == ST_DONE);
   end

   assign s_unit       = r_digits[0];
   assign s_decimal    = r_digits[1];
   assign m_unit       = r_digits[2];
   assign m_decimal    = r_digits[3];
   assign actual_state = r_state;
   assign finish       = r_finish;
   assign tick_1hz     = r_tick;

endmodule

// File: tb/tb_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer
//   Directed testbench for countdown_timer, built with CLK_HZ=4 and
//   DONE_HOLD_S=2. Define TIMER_AUTORELOAD_EN to exercise the auto-reload path.
// -----------------------------------------------------------------------------
module tb_countdown_timer;

   localparam int CLK_HZ      = 4;
   localparam int DONE_HOLD_S = 2;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RUN   = 3'd1;
   localparam logic [2:0] S_PAUSE = 3'd2;
   localparam logic [2:0] S_DONE  = 3'd3;

   logic       clk;
   logic       reset;
   logic       load;
   logic       start_pause;
   logic [3:0] set_m_decimal;
   logic [3:0] set_m_unit;
   logic [3:0] set_s_decimal;
   logic [3:0] set_s_unit;
   logic [3:0] m_decimal;
   logic [3:0] m_unit;
   logic [3:0] s_decimal;
   logic [3:0] s_unit;
   logic [2:0] actual_state;
   logic       finish;
   logic       tick_1hz;

   logic [15:0] val;
   assign val = {m_decimal, m_unit, s_decimal, s_unit};

   int n_checks = 0;
   int n_fail   = 0;

   countdown_timer #(
      .CLK_HZ      (CLK_HZ),
      .DONE_HOLD_S (DONE_HOLD_S)
   ) dut (
      .clk_100MHz    (clk),
      .reset         (reset),
      .load          (load),
      .start_pause   (start_pause),
      .set_m_decimal (set_m_decimal),
      .set_m_unit    (set_m_unit),
      .set_s_decimal (set_s_decimal),
      .set_s_unit    (set_s_unit),
      .m_decimal     (m_decimal),
      .m_unit        (m_unit),
      .s_decimal     (s_decimal),
      .s_unit        (s_unit),
      .actual_state  (actual_state),
      .finish        (finish),
      .tick_1hz      (tick_1hz)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   // Independent model: seconds count to BCD MM:SS.
   function automatic logic [15:0] to_bcd(input int secs);
      int m;
      int s;
      m = secs / 60;
      s = secs % 60;
      return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   // Advance one clock; returns 1 time unit after the rising edge.
   task automatic tick_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic set_preset(input logic [3:0] md, input logic [3:0] mu,
                             input logic [3:0] sd, input logic [3:0] su);
      set_m_decimal = md;
      set_m_unit    = mu;
      set_s_decimal = sd;
      set_s_unit    = su;
   endtask

   task automatic do_load(input logic [3:0] md, input logic [3:0] mu,
                          input logic [3:0] sd, input logic [3:0] su);
      set_preset(md, mu, sd, su);
      load = 1'b1;
      tick_clk();
      load = 1'b0;
   endtask

   task automatic pulse_sp();
      start_pause = 1'b1;
      tick_clk();
      start_pause = 1'b0;
   endtask

   initial begin
      logic seen_tick;

      reset       = 1'b0;
      load        = 1'b0;
      start_pause = 1'b0;
      set_preset(4'd0, 4'd0, 4'd0, 4'd0);
      #1 reset = 1'b1;
      #11;
      check("reset_digits", 32'(val), 32'h0000);
      check("reset_state", 32'(actual_state), 32'(S_IDLE));
      check("reset_finish", 32'(finish), 32'd0);
      check("reset_tick", 32'(tick_1hz), 32'd0);
      tick_clk();
      reset = 1'b0;

      // ---- 01:00 countdown all the way to DONE ----
      do_load(4'd0, 4'd1, 4'd0, 4'd0);
      check("load_0100", 32'(val), 32'h0100);
      check("load_idle", 32'(actual_state), 32'(S_IDLE));
      pulse_sp();
      check("start_run", 32'(actual_state), 32'(S_RUN));
      repeat (3) tick_clk();
      check("pre_tick_low", 32'(tick_1hz), 32'd0);
      check("pre_tick_val", 32'(val), 32'h0100);
      tick_clk();
      check("first_tick", 32'(tick_1hz), 32'd1);
      check("first_dec_0059", 32'(val), 32'h0059);
      for (int k = 1; k <= 59; k++) begin
         repeat (CLK_HZ) tick_clk();
         check($sformatf("count_%0d", 59 - k), 32'(val), 32'(to_bcd(59 - k)));
      end
      check("done_state", 32'(actual_state), 32'(S_DONE));
      check("done_finish", 32'(finish), 32'd1);
      tick_clk();
      check("done_tick_clear", 32'(tick_1hz), 32'd0);
      pulse_sp();
      check("done_sp_ignored", 32'(actual_state), 32'(S_DONE));
      check("done_hold_zero", 32'(val), 32'h0000);

      // ---- 09:59 -> 09:58 ----
      do_load(4'd0, 4'd9, 4'd5, 4'd9);
      check("done_load_state", 32'(actual_state), 32'(S_IDLE));
      check("done_load_finish", 32'(finish), 32'd0);
      check("load_0959", 32'(val), 32'h0959);
      pulse_sp();
      repeat (CLK_HZ) tick_clk();
      check("dec_0958", 32'(val), 32'h0958);

      // ---- 10:00 -> 09:59 (load through PAUSE) ----
      pulse_sp();
      check("pause_state", 32'(actual_state), 32'(S_PAUSE));
      do_load(4'd1, 4'd0, 4'd0, 4'd0);
      check("pause_load_idle", 32'(actual_state), 32'(S_IDLE));
      check("load_1000", 32'(val), 32'h1000);
      pulse_sp();
      repeat (CLK_HZ) tick_clk();
      check("dec_0959", 32'(val), 32'h0959);

      // ---- clamp, load ignored in RUN, pause/resume timing ----
      pulse_sp();
      do_load(4'd1, 4'd15, 4'd7, 4'd12);
      check("clamp_1959", 32'(val), 32'h1959);
      pulse_sp();                        // run, prescaler 0
      do_load(4'd0, 4'd0, 4'd0, 4'd5);   // prescaler 1, load ignored
      check("run_load_ignored", 32'(val), 32'h1959);
      check("run_load_state", 32'(actual_state), 32'(S_RUN));
      pulse_sp();                        // pause with prescaler at 2
      check("pause2_state", 32'(actual_state), 32'(S_PAUSE));
      seen_tick = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick_clk();
         if (tick_1hz) seen_tick = 1'b1;
      end
      check("pause_frozen", 32'(val), 32'h1959);
      check("pause_no_tick", 32'(seen_tick), 32'd0);
      pulse_sp();
      check("resume_state", 32'(actual_state), 32'(S_RUN));
      check("resume_no_tick", 32'(tick_1hz), 32'd0);
      tick_clk();
      check("resume_1_no_tick", 32'(tick_1hz), 32'd0);
      tick_clk();
      check("resume_2_tick", 32'(tick_1hz), 32'd1);
      check("resume_dec_1958", 32'(val), 32'h1958);

      // ---- simultaneous load + start_pause in IDLE; start at 00:00 ----
      pulse_sp();
      do_load(4'd0, 4'd0, 4'd0, 4'd0);
      set_preset(4'd0, 4'd3, 4'd3, 4'd0);
      load        = 1'b1;
      start_pause = 1'b1;
      tick_clk();
      load        = 1'b0;
      start_pause = 1'b0;
      check("ld_sp_val", 32'(val), 32'h0330);
      check("ld_sp_state", 32'(actual_state), 32'(S_IDLE));
      do_load(4'd0, 4'd0, 4'd0, 4'd0);
      pulse_sp();
      check("zero_start_state", 32'(actual_state), 32'(S_DONE));
      check("zero_start_finish", 32'(finish), 32'd1);

      // ---- asynchronous reset mid-RUN ----
      do_load(4'd0, 4'd5, 4'd0, 4'd0);
      pulse_sp();
      repeat (5) tick_clk();
      check("pre_reset_val", 32'(val), 32'h0459);
      check("pre_reset_state", 32'(actual_state), 32'(S_RUN));
      #2 reset = 1'b1;
      #1;
      check("async_rst_val", 32'(val), 32'h0000);
      check("async_rst_state", 32'(actual_state), 32'(S_IDLE));
      check("async_rst_finish", 32'(finish), 32'd0);
      #2 reset = 1'b0;
      tick_clk();

      // ---- DONE hold / auto-reload from 00:02 ----
      do_load(4'd0, 4'd0, 4'd0, 4'd2);
      pulse_sp();
      repeat (2 * CLK_HZ) tick_clk();
      check("ar_done_state", 32'(actual_state), 32'(S_DONE));
      check("ar_done_val", 32'(val), 32'h0000);
`ifdef TIMER_AUTORELOAD_EN
      repeat (DONE_HOLD_S * CLK_HZ - 1) tick_clk();
      check("ar_still_done", 32'(actual_state), 32'(S_DONE));
      tick_clk();
      check("ar_reload_state", 32'(actual_state), 32'(S_IDLE));
      check("ar_reload_val", 32'(val), 32'h0002);
      check("ar_reload_finish", 32'(finish), 32'd0);
`else
      repeat (4 * CLK_HZ) tick_clk();
      check("done_persist_state", 32'(actual_state), 32'(S_DONE));
      check("done_persist_finish", 32'(finish), 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Upstream time source for the VGA painter.
- Holds a BCD MM:SS countdown, loaded from preset digits and started/paused by a pulse.
- Decrements once per second from an internal prescaler off clk_100MHz.
- Drives the four digit buses, the 3-bit state code and the finish flag that the painter renders.

Parameters:
- CLK_HZ, 100000000, input clock frequency; prescaler period in cycles.
- DONE_HOLD_S, 5, seconds spent in DONE before auto-reload (used only with TIMER_AUTORELOAD_EN).

Ports:
- clk_100MHz  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- load  in  1  level; copy preset digits into the counter.
- start_pause  in  1  single-cycle pulse; toggles run/pause.
- set_m_decimal  in  4  preset minutes tens (BCD).
- set_m_unit  in  4  preset minutes units (BCD).
- set_s_decimal  in  4  preset seconds tens (BCD).
- set_s_unit  in  4  preset seconds units (BCD).
- m_decimal  out  4  minutes tens.
- m_unit  out  4  minutes units.
- s_decimal  out  4  seconds tens.
- s_unit  out  4  seconds units.
- actual_state  out  3  state code: IDLE=0, RUN=1, PAUSE=2, DONE=3; codes 4–7 unused.
- finish  out  1  high while in DONE.
- tick_1hz  out  1  one-cycle pulse on each decrement tick, RUN only.

Behaviour:
- Reset state: digits 0, state IDLE, finish 0, tick_1hz 0, prescaler 0. Reset is asynchronous; asserting it mid-count aborts immediately.
- All outputs are registered.
- Preset clamp on load: any digit >9 becomes 9; set_s_decimal >5 becomes 5.
- IDLE:
  - load=1: digits take the clamped preset on the next edge.
  - start_pause pulse: if the value is 00:00, go to DONE; otherwise go to RUN and clear the prescaler.
  - If load and start_pause are high in the same cycle, load wins and the state stays IDLE.
- RUN:
  - Prescaler counts 0..CLK_HZ-1. At terminal count, tick_1hz=1 for one cycle and the value decrements that same edge.
  - start_pause moves to PAUSE; the prescaler value is held, not cleared.
  - load is ignored.
- Decrement (BCD borrow chain):
  - s_unit: 0→9 with borrow, else -1.
  - s_decimal: on borrow, 0→5 with borrow, else -1.
  - m_unit: on borrow, 0→9 with borrow, else -1.
  - m_decimal: on borrow, -1.
  - Examples: 10:00 → 09:59, 01:00 → 00:59.
- Terminal tick: when the tick occurs at 00:01, the value becomes 00:00 and the state becomes DONE on the same edge. finish=1 from that edge. The counter never wraps below 00:00.
- PAUSE:
  - start_pause returns to RUN and the prescaler resumes from its held value.
  - load=1 loads the preset and goes to IDLE. load takes priority over a simultaneous start_pause.
- DONE:
  - Digits hold 00:00, finish=1.
  - load=1 loads the preset, goes to IDLE and clears finish on the same edge.
  - start_pause is ignored.
- Maximum value is 99:59, representable with 4-bit digits.

Optional Feature:
- Macro: TIMER_AUTORELOAD_EN.
- Defined: DONE runs the prescaler; after DONE_HOLD_S ticks, the last loaded preset (kept in a shadow register) is restored and the state returns to IDLE with finish=0. A manual load during the hold still takes effect immediately.
- Undefined: DONE persists until load or reset; no shadow register exists.

Decomposition:
- Shared package timer_pkg:
  - state codes ST_IDLE/ST_RUN/ST_PAUSE/ST_DONE as 3-bit localparams;
  - BCD limit constants BCD_MAX=9 and SEC_TENS_MAX=5.
- One natural sub-module: bcd_down_digit.
  - Parameterized max value.
  - Inputs: digit, borrow_in.
  - Outputs: next digit, borrow_out.
  - Instantiated four times as a borrow chain.

Test Plan (CLK_HZ=4 in the bench):
- Reset asserted asynchronously mid-RUN → all digits 0, actual_state=0, finish=0 before the next clock edge.
- load with preset 01:00, start_pause → after 4 cycles tick_1hz=1 and digits read 00:59; after a further 59 ticks actual_state=3 and finish=1 at 00:00.
- Preset 09:59 → 09:58 on the first tick; preset 10:00 → 09:59; preset with s_decimal=7, s_unit=12 → loads as x:59.
- RUN, start_pause after 2 cycles → PAUSE, digits frozen for 20 cycles; start_pause again → tick arrives 2 cycles after resume.
- Simultaneous load + start_pause in IDLE → preset loaded, actual_state stays 0. start_pause with 00:00 loaded → actual_state=3 and finish=1 next cycle.
- With TIMER_AUTORELOAD_EN, DONE_HOLD_S=2, preset 00:02 → DONE; after 8 cycles actual_state=0, digits 00:02, finish=0.
